// File: rtl/seq_shift_add_multiplier_if.sv
// seq_shift_add_multiplier_if: start/busy/done handshake with operands and the 2N-bit product; master = controller, slave = multiplier
interface seq_shift_add_multiplier_if #(parameter int N = 16);
  logic         start;
  logic         signed_op;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [2*N-1:0] product;
  logic         busy;
  logic         done;
  modport master (output start, signed_op, a, b, input product, busy, done);
  modport slave (input start, signed_op, a, b, output product, busy, done);
endinterface

// File: rtl/seq_shift_add_multiplier.sv
// seq_shift_add_multiplier: radix-2 shift-and-add multiplier, N+2 cycles per product; ports clk, rst_n (async low), s (slave handshake); MULT_SIGNED_EN enables signed MULT
module seq_shift_add_multiplier #(parameter int N = 16) (
  input logic clk,
  input logic rst_n,
  seq_shift_add_multiplier_if.slave s
);
  localparam int CW = $clog2(N);
  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
  state_t state_q, state_d;
  logic [N-1:0] m_q, m_d, q_q, q_d, m_in, q_in;
  logic [N:0] acc_q, acc_d, sum;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2*N-1:0] product_q, product_d, p, p_out;
  logic accept;
  assign accept = s.start & (state_q == IDLE || state_q == DONE);
  assign sum = q_q[0] ? {1'b0, acc_q[N-1:0]} + {1'b0, m_q} : {1'b0, acc_q[N-1:0]};
  assign p = {acc_q[N-1:0], q_q};
`ifdef MULT_SIGNED_EN
  logic neg_q, neg_d;
  assign m_in = (s.signed_op & s.a[N-1]) ? -s.a : s.a;
  assign q_in = (s.signed_op & s.b[N-1]) ? -s.b : s.b;
  assign neg_d = accept ? s.signed_op & (s.a[N-1] ^ s.b[N-1]) : neg_q;
  assign p_out = neg_q ? -p : p;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) neg_q <= 1'b0;
    else neg_q <= neg_d;
`else
  assign m_in = s.a;
  assign q_in = s.b;
  assign p_out = p;
`endif
  always_comb begin
    state_d = state_q;
    m_d = m_q;
    q_d = q_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    product_d = product_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = accept ? RUN : IDLE;
        if (accept) begin
          m_d = m_in;
          q_d = q_in;
          acc_d = '0;
          cnt_d = '0;
        end
      end
      RUN: begin
        // {ACC,Q} <= {c,s,Q} >> 1; ACC's top bit is always zero
        acc_d = {1'b0, sum[N:1]};
        q_d = {sum[0], q_q[N-1:1]};
        cnt_d = cnt_q + 1'b1;
        state_d = (cnt_q == CW'(N - 1)) ? FIX : RUN;
      end
      default: begin
        product_d = p_out;
        state_d = DONE;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      m_q <= '0;
      q_q <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      product_q <= '0;
    end else begin
      state_q <= state_d;
      m_q <= m_d;
      q_q <= q_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      product_q <= product_d;
    end
  assign s.product = product_q;
  assign s.busy = (state_q == RUN) || (state_q == FIX);
  assign s.done = (state_q == DONE);
endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// tb_seq_shift_add_multiplier: directed vectors with hand-computed products, latency, busy length and handshake checks
module tb_seq_shift_add_multiplier;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int errors = 0;
  int checks = 0;
  int edges, busy_cnt, done_cnt;
  seq_shift_add_multiplier_if #(.N(16)) mif ();
  seq_shift_add_multiplier #(.N(16)) dut (.clk(clk), .rst_n(rst_n), .s(mif.slave));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic wait_done();
    edges = 1;
    busy_cnt = 0;
    while (!mif.done && edges < 40) begin
      if (mif.busy) busy_cnt++;
      @(posedge clk);
      #1 edges++;
    end
  endtask
  task automatic run(input string tag, input logic [15:0] ta, input logic [15:0] tb, input logic sg,
                     input logic [31:0] exp);
    @(negedge clk);
    mif.start = 1'b1;
    mif.a = ta;
    mif.b = tb;
    mif.signed_op = sg;
    @(posedge clk);
    #1 mif.start = 1'b0;
    mif.a = '0;
    mif.b = '0;
    mif.signed_op = 1'b0;
    wait_done();
    check({tag, "_lat"}, 64'(edges), 64'd18);
    check({tag, "_prod"}, 64'(mif.product), 64'(exp));
  endtask
  initial begin
    mif.start = 1'b0;
    mif.signed_op = 1'b0;
    mif.a = '0;
    mif.b = '0;
    #12;
    check("rst_product", 64'(mif.product), 64'd0);
    check("rst_busy", 64'(mif.busy), 64'd0);
    check("rst_done", 64'(mif.done), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    run("ffff_sq", 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001);
    check("ffff_busy_len", 64'(busy_cnt), 64'd17);
    check("done_busy_low", 64'(mif.busy), 64'd0);
    @(posedge clk);
    #1 check("done_one_pulse", 64'(mif.done), 64'd0);
    check("prod_held", 64'(mif.product), 64'hFFFE0001);
    run("zero", 16'h0000, 16'hFFFF, 1'b0, 32'h0);
    run("mixed", 16'h1234, 16'h0010, 1'b0, 32'h00012340);
    run("ff_101", 16'h00FF, 16'h0101, 1'b0, 32'h0000FFFF);
`ifdef MULT_SIGNED_EN
    run("sgn_m3x5", 16'hFFFD, 16'h0005, 1'b1, 32'hFFFFFFF1);
    run("sgn_m1sq", 16'hFFFF, 16'hFFFF, 1'b1, 32'h00000001);
`else
    run("sgn_m3x5", 16'hFFFD, 16'h0005, 1'b1, 32'h0004FFF1);
    run("sgn_m1sq", 16'hFFFF, 16'hFFFF, 1'b1, 32'hFFFE0001);
`endif
    run("sgn_min", 16'h8000, 16'h8000, 1'b1, 32'h40000000);
    // start while busy must be ignored
    @(negedge clk);
    mif.start = 1'b1;
    mif.a = 16'h0007;
    mif.b = 16'h0009;
    @(negedge clk);
    mif.start = 1'b0;
    repeat (3) @(negedge clk);
    mif.start = 1'b1;
    mif.a = 16'h1111;
    mif.b = 16'h2222;
    @(negedge clk);
    mif.start = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (mif.done) begin
        done_cnt++;
        check("ign_prod", 64'(mif.product), 64'd63);
      end
    end
    check("ign_done_cnt", 64'(done_cnt), 64'd1);
    // async reset in RUN at count=7
    @(negedge clk);
    mif.start = 1'b1;
    mif.a = 16'h0005;
    mif.b = 16'h0005;
    @(posedge clk);
    #1 mif.start = 1'b0;
    repeat (7) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check("arst_product", 64'(mif.product), 64'd0);
    check("arst_busy", 64'(mif.busy), 64'd0);
    check("arst_done", 64'(mif.done), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    done_cnt = 0;
    repeat (20) @(negedge clk) if (mif.done) done_cnt++;
    check("arst_no_done", 64'(done_cnt), 64'd0);
    run("post_rst", 16'h0003, 16'h0004, 1'b0, 32'h0000000C);
    // back-to-back with start held through DONE
    @(negedge clk);
    mif.start = 1'b1;
    mif.a = 16'h0002;
    mif.b = 16'h0003;
    @(posedge clk);
    #1 wait_done();
    check("b2b1_lat", 64'(edges), 64'd18);
    check("b2b1_prod", 64'(mif.product), 64'h6);
    mif.a = 16'h0010;
    mif.b = 16'h0010;
    @(posedge clk);
    #1 mif.start = 1'b0;
    check("b2b_no_gap", 64'(mif.busy), 64'd1);
    wait_done();
    check("b2b2_lat", 64'(edges), 64'd18);
    check("b2b2_prod", 64'(mif.product), 64'h100);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
